// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, framebuffer geometry and bus state types
//
// Purpose: common constants and types for the framebuffer access path.
// Contents:
//   HD, VD        visible area of the 640x480 scan
//   *_DEF         default framebuffer geometry and bus widths
//   bus_state_e   what the shared RAM bus is doing on a given cycle
package vga_pkg;

  localparam int HD = 640;
  localparam int VD = 480;

  localparam int FB_W_DEF     = 160;
  localparam int FB_H_DEF     = 120;
  localparam int SCALE_SH_DEF = 2;
  localparam int ADDR_W_DEF   = 15;
  localparam int DATA_W_DEF   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - screen pixel coordinates to framebuffer cell address
//
// Purpose: combinational (y>>SCALE_SH)*FB_W + (x>>SCALE_SH).
// Ports:
//   x_i, y_i  current pixel coordinates (10 bits each)
//   addr_o    cell address, computed at ADDR_W+1 bits and truncated
module fb_addr_calc
  import vga_pkg::*;
#(
  parameter int FB_W     = FB_W_DEF,
  parameter int SCALE_SH = SCALE_SH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int SUM_W = ADDR_W + 1;

  logic [SUM_W-1:0] cx;
  logic [SUM_W-1:0] cy;
  logic [SUM_W-1:0] sum;

  always_comb begin
    cx = SUM_W'(x_i >> SCALE_SH);
    cy = SUM_W'(y_i >> SCALE_SH);
    // The default width 160 = 128 + 32 needs only two shifted adds.
    if (FB_W == 160) begin
      sum = (cy << 7) + (cy << 5) + cx;
    end else begin
      sum = cy * SUM_W'(FB_W) + cx;
    end
  end

  assign addr_o = ADDR_W'(sum);

endmodule

// File: rtl/vram_access_arbiter.sv
// rtl/vram_access_arbiter.sv - single-port framebuffer RAM shared by scan-out and a pixel writer
//
// Purpose: display reads take the bus on every active pixel tick; the writer gets
// the remaining cycles through a req/ack handshake. Reads return 3 clocks after the tick.
// Optional feature: define VRAM_VBLANK_WR_EN to restrict writes to blanking (tear-free).
// Ports:
//   clk_100MHz, reset      system clock, asynchronous active-high reset
//   p_tick, video_on, x, y scan timing from the VGA generator
//   wr_req/wr_addr/wr_data writer request, held stable until wr_ack
//   wr_ack, wr_err         1-clk pulses: request consumed / address out of range
//   ram_en/we/addr/wdata   registered RAM control
//   ram_rdata              RAM read data, 1 clk after a read enable
//   pix_rgb, pix_valid     pixel colour to the DAC and its update strobe
module vram_access_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W     = FB_W_DEF,
  parameter int FB_H     = FB_H_DEF,
  parameter int SCALE_SH = SCALE_SH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_valid
);

  localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(FB_W * FB_H);

  bus_state_e        state_q, state_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;

  // Read pipeline: tick seen (s1), RAM sampling (s2), pixel registered.
  logic              s1_vld_q, s1_act_q;
  logic              s2_vld_q, s2_act_q;
  logic [DATA_W-1:0] pix_rgb_q;
  logic              pix_valid_q;

  logic [ADDR_W-1:0] pix_addr;
  logic              rd_now;
  logic              wr_ok;
  logic              addr_err;

  fb_addr_calc #(
    .FB_W    (FB_W),
    .SCALE_SH(SCALE_SH),
    .ADDR_W  (ADDR_W)
  ) u_addr (
    .x_i   (x),
    .y_i   (y),
    .addr_o(pix_addr)
  );

  always_comb begin
    rd_now = p_tick && video_on;
    // The !wr_ack_q term stops a request still held in its ack cycle from being taken twice.
    wr_ok  = wr_req && !wr_ack_q && !rd_now;
`ifdef VRAM_VBLANK_WR_EN
    wr_ok  = wr_ok && !video_on;
`endif
    addr_err = {1'b0, wr_addr} >= CELLS;

    state_d     = IDLE;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;

    if (rd_now) begin
      state_d    = RD;
      ram_addr_d = pix_addr;
    end else if (wr_ok) begin
      state_d     = WR;
      ram_we_d    = !addr_err;
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
      wr_err_d    = addr_err;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_act_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_act_q    <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      s1_vld_q    <= p_tick;
      s1_act_q    <= video_on;
      s2_vld_q    <= s1_vld_q;
      s2_act_q    <= s1_act_q;
      pix_valid_q <= s2_vld_q;
      // Blanking ticks never touched the RAM, so their pixel is forced black.
      if (s2_vld_q) begin
        pix_rgb_q <= s2_act_q ? ram_rdata : '0;
      end
    end
  end

  assign ram_en    = (state_q != IDLE);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign pix_rgb   = pix_rgb_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb/tb_vram_access_arbiter.sv - self-checking bench for vram_access_arbiter
module tb_vram_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick, video_on, wr_req;
  logic [9:0]  x, y;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack, wr_err, ram_en, ram_we, pix_valid;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata, ram_rdata, pix_rgb;

  always #5 clk = ~clk;

  vram_access_arbiter dut (
    .clk_100MHz(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid)
  );

  // Single-port RAM attached to the DUT, contents start as a known pattern.
  logic [11:0] env_mem [32768];
  bit          env_init;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 32768; i++) env_mem[i] <= 12'(i * 7 + 3);
      env_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) env_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= env_mem[ram_addr];
    end
  end

  // Reference model state
  typedef struct { int due; logic [11:0] rgb; } pev_t;
  pev_t        pend[$];
  logic [11:0] ref_mem [32768];
  int          checks, errors, cyc;
  logic        m_prev_ack;
  bit          hold_req;
  logic        exp_rd, exp_ack, exp_err, exp_we, exp_pv;
  logic [14:0] exp_addr;
  logic [11:0] exp_rgb;

  // One clock: drive scan inputs, take the edge, then derive what the spec requires.
  task automatic advance(input logic tick, input logic von, input int xx, input int yy);
    logic rd, grant;
    int   a;
    pev_t ev;
    p_tick = tick; video_on = von; x = 10'(xx); y = 10'(yy);
    @(posedge clk); #1; cyc++;
    rd    = tick && von;
    grant = wr_req && !m_prev_ack && !rd;
`ifdef VRAM_VBLANK_WR_EN
    grant = grant && !von;
`endif
    a        = (yy / 4) * 160 + (xx / 4);
    exp_rd   = rd;
    exp_addr = 15'(a);
    exp_ack  = grant;
    exp_err  = grant && (int'(wr_addr) >= 19200);
    exp_we   = grant && !exp_err;
    m_prev_ack = grant;
    if (tick) begin
      ev.due = cyc + 2;
      ev.rgb = von ? ref_mem[a] : 12'h000;
      pend.push_back(ev);
    end
    exp_pv = 1'b0; exp_rgb = 12'h000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_pv = 1'b1; exp_rgb = pend[0].rgb; pend.delete(0);
    end
    if (exp_we) ref_mem[wr_addr] = wr_data;
    if (!hold_req && wr_ack) wr_req = 1'b0;
  endtask

  task automatic test_power_on_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wr_ack, wr_err, ram_en, ram_we, ram_addr, ram_wdata, pix_rgb, pix_valid} !== 45'd0) begin
      errors++; $display("FAIL por_outputs got %h want 0", {wr_ack, wr_err, ram_en, ram_we, ram_addr, ram_wdata, pix_rgb, pix_valid});
    end
    reset = 1'b0;
  endtask

  task automatic test_pixel();
    bit acked = 0;
    wr_req = 1'b1; wr_addr = 15'd321; wr_data = 12'hABC;
    for (int i = 0; i < 4 && !acked; i++) begin
      advance(1'b0, 1'b0, 700, 0);
      if (wr_ack) acked = 1;
    end
    checks++;
    if (!acked) begin errors++; $display("FAIL pixel_preload_ack got 0 want 1"); end
    advance(1'b0, 1'b0, 700, 0);
    advance(1'b1, 1'b1, 5, 9);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'd321) begin
      errors++; $display("FAIL pixel_rd_addr got en=%b we=%b addr=%0d want 1 0 321", ram_en, ram_we, ram_addr);
    end
    advance(1'b0, 1'b1, 5, 9);
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL pixel_early got %b want 0", pix_valid); end
    advance(1'b0, 1'b1, 5, 9);
    checks++;
    if (pix_valid !== 1'b1 || pix_rgb !== 12'hABC) begin
      errors++; $display("FAIL pixel_rgb got v=%b rgb=%h want 1 abc", pix_valid, pix_rgb);
    end
    advance(1'b0, 1'b1, 5, 9);
  endtask

  task automatic test_collide();
    int acks = 0;
    advance(1'b0, 1'b0, 700, 0);
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 12'h0F0;
    advance(1'b1, 1'b1, 200, 200);
    checks++;
    if (wr_ack !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
      errors++; $display("FAIL collide_rd_first got ack=%b en=%b we=%b want 0 1 0", wr_ack, ram_en, ram_we);
    end
    advance(1'b0, 1'b1, 200, 200);
    checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd100 || ram_wdata !== 12'h0F0) begin
      errors++; $display("FAIL collide_wr_next got ack=%b we=%b addr=%0d data=%h want 1 1 100 0f0", wr_ack, ram_we, ram_addr, ram_wdata);
    end
    if (wr_ack) acks++;
    for (int i = 0; i < 3; i++) begin
      advance(1'b0, 1'b1, 200, 200);
      if (wr_ack) acks++;
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL collide_ack_count got %0d want 1", acks); end
    advance(1'b1, 1'b1, 401, 2);
    advance(1'b0, 1'b1, 401, 2);
    advance(1'b0, 1'b1, 401, 2);
    checks++;
    if (pix_valid !== 1'b1 || pix_rgb !== 12'h0F0) begin
      errors++; $display("FAIL collide_readback got v=%b rgb=%h want 1 0f0", pix_valid, pix_rgb);
    end
  endtask

  task automatic test_oob();
    int acks = 0, errs = 0, wes = 0;
    advance(1'b0, 1'b0, 700, 0);
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 12'hFFF;
    for (int i = 0; i < 6; i++) begin
      advance(1'b0, 1'b0, 700, 0);
      if (wr_ack) acks++;
      if (wr_ack && wr_err) errs++;
      if (ram_we) wes++;
    end
    checks++;
    if (acks != 1 || errs != 1) begin errors++; $display("FAIL oob_ack_err got ack=%0d err=%0d want 1 1", acks, errs); end
    checks++;
    if (wes != 0) begin errors++; $display("FAIL oob_we got %0d want 0", wes); end
    checks++;
    if (env_mem[19200] !== 12'hD03) begin errors++; $display("FAIL oob_ram got %h want d03", env_mem[19200]); end
  endtask

  task automatic test_back_to_back();
    int   acks = 0;
    logic prev = 1'b0;
    advance(1'b0, 1'b0, 700, 0);
    advance(1'b0, 1'b0, 700, 0);
    hold_req = 1; wr_req = 1'b1; wr_addr = 15'd50; wr_data = 12'h555;
    for (int c = 0; c < 8; c++) begin
      advance(c % 4 == 0, 1'b1, 40 + c, 60);
      checks++;
      if (wr_ack !== exp_ack || (wr_ack && prev) || (wr_ack && exp_rd)) begin
        errors++; $display("FAIL b2b_ack c=%0d got %b want %b prev=%b rd=%b", c, wr_ack, exp_ack, prev, exp_rd);
      end
      if (wr_ack) acks++;
      prev = wr_ack;
    end
    hold_req = 0; wr_req = 1'b0;
    checks++;
`ifdef VRAM_VBLANK_WR_EN
    if (acks != 0) begin errors++; $display("FAIL b2b_count got %0d want 0", acks); end
`else
    if (acks != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", acks); end
`endif
    advance(1'b0, 1'b0, 700, 0);
  endtask

  task automatic test_reset();
    advance(1'b0, 1'b0, 700, 0);
    wr_req = 1'b1; wr_addr = 15'd500; wr_data = 12'h123;
    advance(1'b1, 1'b1, 100, 100);
    reset = 1'b1; #1;
    checks++;
    if ({wr_ack, wr_err, ram_en, ram_we, ram_addr, ram_wdata, pix_rgb, pix_valid} !== 45'd0) begin
      errors++; $display("FAIL reset_async got %h want 0", {wr_ack, wr_err, ram_en, ram_we, ram_addr, ram_wdata, pix_rgb, pix_valid});
    end
    wr_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (pix_valid !== 1'b0 || wr_ack !== 1'b0 || ram_en !== 1'b0) begin
      errors++; $display("FAIL reset_hold got v=%b ack=%b en=%b want 0 0 0", pix_valid, wr_ack, ram_en);
    end
    reset = 1'b0;
    pend.delete(); m_prev_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      advance(1'b0, 1'b0, 700, 0);
      checks++;
      if (pix_valid !== 1'b0 || ram_en !== 1'b0) begin
        errors++; $display("FAIL reset_flush got v=%b en=%b want 0 0", pix_valid, ram_en);
      end
    end
    advance(1'b1, 1'b1, 20, 40);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'd1605) begin
      errors++; $display("FAIL reset_first_rd got en=%b we=%b addr=%0d want 1 0 1605", ram_en, ram_we, ram_addr);
    end
    advance(1'b0, 1'b1, 20, 40);
    advance(1'b0, 1'b1, 20, 40);
    checks++;
    if (pix_valid !== 1'b1 || pix_rgb !== 12'hBE6) begin
      errors++; $display("FAIL reset_first_pix got v=%b rgb=%h want 1 be6", pix_valid, pix_rgb);
    end
  endtask

  task automatic test_random(input int ncyc);
    int   xx = 0, yy = 0;
    logic von = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c % 4 == 0) begin
        von = ($urandom_range(0, 3) != 0);
        xx  = von ? int'($urandom_range(0, 639)) : int'($urandom_range(640, 799));
        yy  = int'($urandom_range(0, 479));
      end
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req  = 1'b1;
        wr_addr = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
        wr_data = 12'($urandom);
      end
      advance(c % 4 == 0, von, xx, yy);
      checks++;
      if (wr_ack !== exp_ack || wr_err !== exp_err) begin
        errors++; $display("FAIL rnd_ack c=%0d got %b%b want %b%b", c, wr_ack, wr_err, exp_ack, exp_err);
      end
      checks++;
      if (ram_en !== (exp_rd || exp_ack) || ram_we !== exp_we) begin
        errors++; $display("FAIL rnd_bus c=%0d got en=%b we=%b want %b %b", c, ram_en, ram_we, exp_rd || exp_ack, exp_we);
      end
      if (exp_rd) begin
        checks++;
        if (ram_addr !== exp_addr) begin errors++; $display("FAIL rnd_rd_addr c=%0d got %0d want %0d", c, ram_addr, exp_addr); end
      end
      if (exp_we) begin
        checks++;
        if (ram_addr !== wr_addr || ram_wdata !== wr_data) begin
          errors++; $display("FAIL rnd_wr c=%0d got %0d/%h want %0d/%h", c, ram_addr, ram_wdata, wr_addr, wr_data);
        end
      end
      checks++;
      if (pix_valid !== exp_pv || (exp_pv && pix_rgb !== exp_rgb)) begin
        errors++; $display("FAIL rnd_pix c=%0d got %b/%h want %b/%h", c, pix_valid, pix_rgb, exp_pv, exp_rgb);
      end
    end
  endtask

`ifdef VRAM_VBLANK_WR_EN
  task automatic test_vblank();
    bit acked = 0;
    advance(1'b0, 1'b0, 700, 0);
    wr_req = 1'b1; wr_addr = 15'd7; wr_data = 12'h777;
    for (int c = 0; c < 12; c++) begin
      advance(c % 4 == 0, 1'b1, 10 + c / 4, 10);
      checks++;
      if (wr_ack !== 1'b0 || pix_valid !== exp_pv || (exp_pv && pix_rgb !== exp_rgb)) begin
        errors++; $display("FAIL vblank_active c=%0d got ack=%b pix=%b/%h want 0 %b/%h", c, wr_ack, pix_valid, pix_rgb, exp_pv, exp_rgb);
      end
    end
    for (int c = 0; c < 8 && !acked; c++) begin
      advance(c % 4 == 0, 1'b0, 640, 10);
      if (wr_ack) acked = 1;
    end
    checks++;
    if (!acked) begin errors++; $display("FAIL vblank_ack got 0 want 1"); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0; m_prev_ack = 1'b0; hold_req = 0;
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 12'(i * 7 + 3);
    test_power_on_reset();
    test_pixel();
    test_collide();
    test_oob();
    test_back_to_back();
    test_reset();
    test_random(3000);
`ifdef VRAM_VBLANK_WR_EN
    test_vblank();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
